// File: rtl/timer_irq_pkg.sv
// Shared constants for the timer_irq block: register offsets, FSM state
// encoding, MODE encodings and CTRL bit positions.
package timer_irq_pkg;

    // Register word offsets
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // FSM state encoding (visible through STATUS, so the values are fixed)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // MODE field encodings; 1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    // Only the exact auto-reload code reloads; every other code is one-shot.
    function automatic logic mode_is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD) && (mode != MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/timer_irq_regs.sv
// Register file for timer_irq: CTRL and PRESET storage plus the
// combinational read mux. COUNT and STATUS values are supplied by the top.
module timer_irq_regs
    import timer_irq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic        en_clr,
    input  logic [31:0] count,
    input  logic [31:0] status,
    output logic [31:0] rdata,
    output logic        ctrl_en,
    output logic [1:0]  ctrl_mode,
    output logic        ctrl_im,
    output logic [31:0] preset,
    output logic        ctrl_wr
);

    logic [CTRL_W-1:0] ctrl_q;
    logic              preset_wr;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

    assign ctrl_en   = ctrl_q[CTRL_EN];
    assign ctrl_mode = ctrl_q[CTRL_MODE_LO +: 2];
    assign ctrl_im   = ctrl_q[CTRL_IM];

    // CTRL/PRESET storage; a software CTRL write wins over the one-shot EN clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            preset <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_q <= wdata[CTRL_W-1:0];
            end else if (en_clr) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end
            if (preset_wr) begin
                preset <= wdata;
            end
        end
    end

    // Read mux; unimplemented CTRL bits read as zero
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            ADDR_STATUS: rdata = status;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/timer_irq.sv
// timer_irq: down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. The FSM and COUNT live here; registers are in
// timer_irq_regs. Define TIMER_IRQ_STATUS_EN to make STATUS report
// {irq_flag, state}; otherwise STATUS reads zero.
module timer_irq
    import timer_irq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] count_q;
    logic [31:0] preset;
    logic [31:0] status_word;
    logic [1:0]  state_bits;
    logic [1:0]  ctrl_mode;
    logic        irq_flag_q;
    logic        ctrl_en;
    logic        ctrl_im;
    logic        ctrl_wr;
    logic        reload;
    logic        en_clr;
    logic        count_load;
    logic        count_dec;
    logic        flag_set;
    logic        flag_clr;

    // FSM sees the registered MODE, so a CTRL write in INT only affects later edges
    assign reload     = mode_is_reload(ctrl_mode);
    assign state_bits = state_q;

`ifdef TIMER_IRQ_STATUS_EN
    assign status_word = {28'b0, irq_flag_q, 1'b0, state_bits};
`else
    assign status_word = '0;
`endif

    timer_irq_regs u_regs (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .en_clr    (en_clr),
        .count     (count_q),
        .status    (status_word),
        .rdata     (rdata),
        .ctrl_en   (ctrl_en),
        .ctrl_mode (ctrl_mode),
        .ctrl_im   (ctrl_im),
        .preset    (preset),
        .ctrl_wr   (ctrl_wr)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; EN=0 during counting takes priority over expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ctrl_en) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_CNT;
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d = ST_INT;
                end
            end
            ST_INT:  state_d = reload ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: count control, EN auto-clear and interrupt flag set/clear
    always_comb begin
        count_load = (state_q == ST_LOAD);
        count_dec  = (state_q == ST_CNT) && ctrl_en && (count_q != '0);
        flag_set   = (state_q == ST_CNT) && ctrl_en && (count_q == '0);
        en_clr     = (state_q == ST_INT) && !reload;
        flag_clr   = ctrl_wr || ((state_q == ST_INT) && reload);
    end

    // COUNT and irq_flag; setting the flag beats any coincident clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            if (count_load) begin
                count_q <= preset;
            end else if (count_dec) begin
                count_q <= count_q - 32'd1;
            end
            if (flag_set) begin
                irq_flag_q <= 1'b1;
            end else if (flag_clr) begin
                irq_flag_q <= 1'b0;
            end
        end
    end

    assign irq = irq_flag_q & ctrl_im;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq. Expected values come from timing
// arithmetic: the interrupt appears N+3 edges after the enabling write and,
// in auto-reload, repeats every N+3 edges.
module tb_timer_irq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    timer_irq dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] exp_status(input logic flag, input logic [1:0] st);
`ifdef TIMER_IRQ_STATUS_EN
        return {28'b0, flag, 1'b0, st};
`else
        return (flag & 1'b0) ? {30'b0, st} : 32'd0;
`endif
    endfunction

    // Expected irq k edges after the enabling write
    function automatic logic exp_irq(input int k, input int n, input logic rl, input logic im);
        if (k < n + 3) return 1'b0;
        if (!rl) return im;
        return im && (((k - (n + 3)) % (n + 3)) == 0);
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            n_cmp++;
            if (d !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d: got %0h expected 0", a, d); end
        end
        addr = 2'd1; wdata = 32'h1234; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
        reset = 1'b0;
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL reset_write_ignored: got %0h expected 0", d); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (irq !== (k >= 8)) begin n_err++; $display("FAIL oneshot_irq k=%0d: got %0b expected %0b", k, irq, (k >= 8)); end
        end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl: got %0h expected 8", d); end
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL oneshot_count: got %0h expected 0", d); end
        rd(2'd3, d);
        n_cmp++;
        if (d !== exp_status(1'b1, 2'd0)) begin n_err++; $display("FAIL oneshot_status: got %0h expected %0h", d, exp_status(1'b1, 2'd0)); end
        wr(2'd0, 32'h0);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_clear: got %0b expected 0", irq); end
    endtask

    task automatic test_autoreload();
        int pulses = 0;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_cmp++;
            if (irq !== exp_irq(k, 2, 1'b1, 1'b1)) begin
                n_err++; $display("FAIL reload_irq k=%0d: got %0b expected %0b", k, irq, exp_irq(k, 2, 1'b1, 1'b1));
            end
            if (irq === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 3) begin n_err++; $display("FAIL reload_pulses: got %0d expected 3", pulses); end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_cmp++;
            if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq k=%0d: got %0b expected 0", k, irq); end
        end
        rd(2'd3, d);
        n_cmp++;
        if (d !== exp_status(1'b1, 2'd0)) begin n_err++; $display("FAIL mask_status: got %0h expected %0h", d, exp_status(1'b1, 2'd0)); end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL mask_ctrl: got %0h expected 0", d); end
    endtask

    task automatic test_pause();
        logic [31:0] d;
        logic found = 1'b0;
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 40; i++) begin
            rd(2'd2, d);
            if (d == 32'd7) begin found = 1'b1; break; end
            tick();
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL pause_reach7: got %0h expected 7", d); end
        wr(2'd0, 32'h8);
        repeat (3) tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd6) begin n_err++; $display("FAIL pause_count: got %0h expected 6", d); end
        rd(2'd3, d);
        n_cmp++;
        if (d !== exp_status(1'b0, 2'd0)) begin n_err++; $display("FAIL pause_status: got %0h expected %0h", d, exp_status(1'b0, 2'd0)); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL pause_irq: got %0b expected 0", irq); end
    endtask

    task automatic test_midcount_reset();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        repeat (20) tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd82) begin n_err++; $display("FAIL midrst_counting: got %0d expected 82", d); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL midrst_irq: got %0b expected 0", irq); end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            n_cmp++;
            if (d !== 32'd0) begin n_err++; $display("FAIL midrst_reg%0d: got %0h expected 0", a, d); end
        end
        addr = 2'd0; wdata = 32'h9; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
        reset = 1'b0;
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL midrst_write_ignored: got %0h expected 0", d); end
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if (irq !== (k >= 4)) begin n_err++; $display("FAIL midrst_fresh k=%0d: got %0b expected %0b", k, irq, (k >= 4)); end
        end
    endtask

    task automatic test_coincident();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_cmp++;
            if (irq !== 1'b0) begin n_err++; $display("FAIL coinc_early k=%0d: got %0b expected 0", k, irq); end
        end
        wr(2'd0, 32'h9);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL coinc_set_beats_clear: got %0b expected 1", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL coinc_hold: got %0b expected 1", irq); end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h8) begin n_err++; $display("FAIL coinc_ctrl: got %0h expected 8", d); end
    endtask

    task automatic test_mode_switch();
        logic [31:0] d;
        logic        e;
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 7; k++) begin
            if (k == 4) wr(2'd0, 32'h9);
            else tick();
            e = (k == 3) || (k >= 6);
            n_cmp++;
            if (irq !== e) begin n_err++; $display("FAIL modesw_irq k=%0d: got %0b expected %0b", k, irq, e); end
        end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h8) begin n_err++; $display("FAIL modesw_ctrl: got %0h expected 8", d); end
    endtask

    task automatic test_preset_during_cnt();
        logic [31:0] d;
        logic        e;
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                wr(2'd1, 32'd1);
                rd(2'd2, d);
                n_cmp++;
                if (d !== 32'd3) begin n_err++; $display("FAIL preset_cnt_count: got %0h expected 3", d); end
            end else begin
                tick();
            end
            e = (k == 7) || (k == 11) || (k == 15);
            n_cmp++;
            if (irq !== e) begin n_err++; $display("FAIL preset_cnt_irq k=%0d: got %0b expected %0b", k, irq, e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int          n;
        int          kmax;
        logic [1:0]  mode;
        logic        im;
        logic        rl;
        for (int t = 0; t < 10; t++) begin
            n    = int'($urandom_range(0, 6));
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            rl   = (mode == 2'b01);
            do_reset();
            wr(2'd1, 32'(n));
            wr(2'd0, 32'({im, mode, 1'b1}));
            kmax = 3 * (n + 3) + 1;
            for (int k = 1; k <= kmax; k++) begin
                tick();
                n_cmp++;
                if (irq !== exp_irq(k, n, rl, im)) begin
                    n_err++;
                    $display("FAIL rand_irq t=%0d n=%0d mode=%0d im=%0b k=%0d: got %0b expected %0b",
                             t, n, mode, im, k, irq, exp_irq(k, n, rl, im));
                end
            end
            if (!rl) begin
                rd(2'd0, d);
                n_cmp++;
                if (d !== 32'({im, mode, 1'b0})) begin
                    n_err++; $display("FAIL rand_ctrl t=%0d: got %0h expected %0h", t, d, 32'({im, mode, 1'b0}));
                end
                rd(2'd3, d);
                n_cmp++;
                if (d !== exp_status(1'b1, 2'd0)) begin
                    n_err++; $display("FAIL rand_status t=%0d: got %0h expected %0h", t, d, exp_status(1'b1, 2'd0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_pause();
        test_midcount_reset();
        test_coincident();
        test_mode_switch();
        test_preset_during_cnt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
